// File: rtl/inst_encoder_loader_pkg.sv
// Shared definitions for the instruction encoder/loader.
//   - instruction class codes (same encoding the main control decoder emits)
//   - RV32 major opcodes
//   - loader FSM state encoding
//   - field bundle struct handed to the packer
package inst_encoder_loader_pkg;

  typedef enum logic [2:0] {
    CLS_R      = 3'b000,
    CLS_IALU   = 3'b001,
    CLS_LOAD   = 3'b010,
    CLS_STORE  = 3'b011,
    CLS_BRANCH = 3'b100,
    CLS_JAL    = 3'b101,
    CLS_LUI    = 3'b110,
    CLS_SYSTEM = 3'b111
  } cls_e;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    cls_e        cls;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } bundle_t;

endpackage

// File: rtl/inst_encoder_loader_if.sv
// Field-bundle input handshake plus instruction-memory write port.
//   master : the loader (accepts bundles, drives the write port)
//   slave  : the environment (offers bundles, acknowledges writes)
interface inst_encoder_loader_if #(
  parameter int ADDR_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [2:0]        in_cls;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [31:0]       in_imm;
  logic              imem_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    input  in_valid, in_last, in_cls, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm, imem_ready,
    output in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    output in_valid, in_last, in_cls, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm, imem_ready,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/inst_encoder_loader_pack.sv
// inst_pack: purely combinational RV32 packer.
//   bnd  : class code plus register/funct/immediate fields
//   word : 32-bit instruction; fields the class does not use are ignored
module inst_pack
  import inst_encoder_loader_pkg::*;
(
  input  bundle_t     bnd,
  output logic [31:0] word
);

  always_comb begin
    word = '0;
    case (bnd.cls)
      CLS_R:      word = {bnd.funct7, bnd.rs2, bnd.rs1, bnd.funct3, bnd.rd, OPC_R};
      CLS_IALU:   word = {bnd.imm[11:0], bnd.rs1, bnd.funct3, bnd.rd, OPC_I};
      CLS_LOAD:   word = {bnd.imm[11:0], bnd.rs1, bnd.funct3, bnd.rd, OPC_LOAD};
      CLS_STORE:  word = {bnd.imm[11:5], bnd.rs2, bnd.rs1, bnd.funct3,
                          bnd.imm[4:0], OPC_STORE};
      // branch offsets are halfword multiples, so imm[0] is dropped
      CLS_BRANCH: word = {bnd.imm[12], bnd.imm[10:5], bnd.rs2, bnd.rs1, bnd.funct3,
                          bnd.imm[4:1], bnd.imm[11], OPC_BRANCH};
      CLS_JAL:    word = {bnd.imm[20], bnd.imm[10:1], bnd.imm[11], bnd.imm[19:12],
                          bnd.rd, OPC_JAL};
      CLS_LUI:    word = {bnd.imm[31:12], bnd.rd, OPC_LUI};
      // ecall/ebreak select via imm[11:0]; all register fields are zero
      CLS_SYSTEM: word = {bnd.imm[11:0], 5'd0, 3'd0, 5'd0, OPC_SYSTEM};
      default:    word = '0;
    endcase
  end

endmodule

// File: rtl/inst_encoder_loader.sv
// inst_encoder_loader: packs field bundles into RV32 words, buffers them in a
// small FIFO and writes them to instruction memory at contiguous addresses.
//   clk, rst_n   : clock, synchronous active-low reset
//   start        : begins a load session (only honoured in IDLE)
//   bus (master) : bundle handshake in, imem write port out
//   busy         : session in progress (state != IDLE)
//   done         : one-cycle pulse once the last word has been written
//   err_overflow : sticky, more than MAX_WORDS bundles offered this session
module inst_encoder_loader
  import inst_encoder_loader_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int                MAX_WORDS  = 256,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  inst_encoder_loader_if.master bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err_overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(MAX_WORDS + 1);

  state_e            state_q, state_d;
  logic [PW:0]       wr_ptr, rd_ptr;
  logic [31:0]       mem [FIFO_DEPTH];
  logic [CW-1:0]     word_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              err_q;
  logic              rdy;
  logic              empty, full, at_limit;
  logic              accept, push, drop, pop;
  bundle_t           bnd;
  logic [31:0]       enc_word;

  assign bnd = '{cls:    cls_e'(bus.in_cls),
                 rd:     bus.in_rd,
                 rs1:    bus.in_rs1,
                 rs2:    bus.in_rs2,
                 funct3: bus.in_funct3,
                 funct7: bus.in_funct7,
                 imm:    bus.in_imm};

  inst_pack u_pack (
    .bnd  (bnd),
    .word (enc_word)
  );

  // extra pointer MSB distinguishes full from empty
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign at_limit = (word_cnt == CW'(MAX_WORDS));

  // past the session limit bundles are swallowed so upstream can still
  // reach in_last, but nothing more goes into the FIFO
  assign accept = bus.in_valid && rdy;
  assign push   = accept && !at_limit;
  assign drop   = accept && at_limit;
  assign pop    = !empty && bus.imem_ready;

  always_comb begin
    state_d = state_q;
    rdy     = 1'b0;
    done    = 1'b0;
    busy    = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN: begin
        rdy = at_limit || !full;
        if (bus.in_valid && rdy && bus.in_last) state_d = ST_FLUSH;
      end
      ST_FLUSH: if (empty) state_d = ST_DONE;
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      addr_q   <= BASE_ADDR;
      word_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      // FIFO is always empty in IDLE, so the reload cannot race a pop
      if (state_q == ST_IDLE && start) begin
        addr_q   <= BASE_ADDR;
        word_cnt <= '0;
        err_q    <= 1'b0;
      end
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        word_cnt <= word_cnt + CW'(1);
      end
      if (drop) err_q <= 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        addr_q <= addr_q + ADDR_W'(4);
      end
    end
  end

  // storage carries no reset; stale entries are masked by the pointers
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PW-1:0]] <= enc_word;
  end

  assign bus.in_ready   = rdy;
  assign bus.imem_we    = !empty;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = empty ? 32'd0 : mem[rd_ptr[PW-1:0]];
  assign err_overflow   = err_q;

endmodule

// File: tb/tb_inst_encoder_loader.sv
module tb_inst_encoder_loader;
  import inst_encoder_loader_pkg::*;

  localparam int MAXW_A = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start_a, start_b;
  logic busy_a, done_a, err_a, busy_b, done_b, err_b;

  inst_encoder_loader_if #(.ADDR_W(32)) ifa ();
  inst_encoder_loader_if #(.ADDR_W(32)) ifb ();

  inst_encoder_loader #(.ADDR_W(32), .BASE_ADDR(32'h0), .MAX_WORDS(MAXW_A), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start_a), .bus(ifa.master),
    .busy(busy_a), .done(done_a), .err_overflow(err_a));

  inst_encoder_loader #(.ADDR_W(32), .BASE_ADDR(32'h0), .MAX_WORDS(2), .FIFO_DEPTH(4)) u_ovf (
    .clk(clk), .rst_n(rst_n), .start(start_b), .bus(ifb.master),
    .busy(busy_b), .done(done_b), .err_overflow(err_b));

  int vectors = 0, miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference encoder built from the field placement rules with shifts/masks
  function automatic logic [31:0] enc(input logic [31:0] cls, rd, rs1, rs2, f3, f7, imm);
    logic [31:0] r;
    case (cls)
      0: r = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
      1: r = ((imm & 32'hfff) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
      2: r = ((imm & 32'hfff) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h03;
      3: r = (((imm >> 5) & 32'h7f) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
           | ((imm & 32'h1f) << 7) | 32'h23;
      4: r = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3f) << 25) | (rs2 << 20)
           | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hf) << 8)
           | (((imm >> 11) & 1) << 7) | 32'h63;
      5: r = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3ff) << 21)
           | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hff) << 12) | (rd << 7) | 32'h6f;
      6: r = (imm & 32'hfffff000) | (rd << 7) | 32'h37;
      default: r = ((imm & 32'hfff) << 20) | 32'h73;
    endcase
    return r;
  endfunction

  // ---------------- scoreboard for the main instance ----------------
  typedef struct { logic [31:0] a; logic [31:0] w; } exp_t;
  exp_t q[$];
  exp_t wlog[$];
  int          m_state = 0;  // 0 idle, 1 accepting, 2 draining
  logic [31:0] m_addr = 0;
  int          m_cnt = 0;
  bit          m_err = 0;
  int          done_a_cnt = 0;

  always @(negedge clk) begin
    exp_t e;
    check("busy", busy_a, (m_state != 0));
    check("imem_we", ifa.imem_we, (q.size() != 0));
    check("err_overflow", err_a, m_err);
    if (!rst_n) begin
      q.delete();
      m_state = 0; m_addr = 0; m_cnt = 0; m_err = 0;
    end else begin
      if (m_state == 0 && start_a) begin
        m_state = 1; m_addr = 0; m_cnt = 0; m_err = 0;
      end
      if (done_a) begin
        check("done_at_end", (m_state == 2 && q.size() == 0), 1);
        done_a_cnt++;
        m_state = 0;
      end
      if (ifa.imem_we && ifa.imem_ready) begin
        if (q.size() == 0) check("unexpected_write", 1, 0);
        else begin
          e = q.pop_front();
          check("wr_addr", ifa.imem_addr, e.a);
          check("wr_data", ifa.imem_wdata, e.w);
          e.a = ifa.imem_addr; e.w = ifa.imem_wdata;
          wlog.push_back(e);
        end
      end
      if (ifa.in_valid && ifa.in_ready) begin
        check("accept_in_run", m_state, 1);
        if (m_cnt < MAXW_A) begin
          e.a = m_addr;
          e.w = enc(32'(ifa.in_cls), 32'(ifa.in_rd), 32'(ifa.in_rs1), 32'(ifa.in_rs2),
                    32'(ifa.in_funct3), 32'(ifa.in_funct7), ifa.in_imm);
          q.push_back(e);
          m_addr += 4;
          m_cnt++;
        end else m_err = 1;
        if (ifa.in_last) m_state = 2;
      end
    end
  end

  int writes_b = 0, done_b_cnt = 0;
  always @(negedge clk) begin
    if (rst_n && ifb.imem_we && ifb.imem_ready) writes_b++;
    if (rst_n && done_b) done_b_cnt++;
  end

  // ---------------- drivers ----------------
  bit rnd_ready = 0;

  task automatic tick();
    @(posedge clk); #1;
    if (rnd_ready) ifa.imem_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_a(input logic [2:0] cls, input logic [4:0] rd, rs1, rs2,
                        input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm, input bit last);
    bit acc = 0;
    ifa.in_valid = 1; ifa.in_last = last; ifa.in_cls = cls; ifa.in_rd = rd;
    ifa.in_rs1 = rs1; ifa.in_rs2 = rs2; ifa.in_funct3 = f3; ifa.in_funct7 = f7;
    ifa.in_imm = imm;
    for (int i = 0; i < 500 && !acc; i++) begin
      @(negedge clk); acc = ifa.in_ready;
      tick();
    end
    ifa.in_valid = 0; ifa.in_last = 0;
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic send_b(input logic [31:0] imm, input bit last);
    bit acc = 0;
    ifb.in_valid = 1; ifb.in_last = last; ifb.in_cls = 3'b001; ifb.in_imm = imm;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk); acc = ifb.in_ready;
      @(posedge clk); #1;
    end
    ifb.in_valid = 0; ifb.in_last = 0;
    if (!acc) check("send_b_timeout", 0, 1);
  endtask

  task automatic wait_done_a(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk); seen = done_a;
      tick();
    end
    check("done_seen", seen, 1);
  endtask

  task automatic pulse_start_a();
    start_a = 1; tick(); start_a = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_w [5];
    logic [31:0] first_w;
    int d0, n;
    exp_w = '{32'h002081B3, 32'h0020B423, 32'hFE208EE3, 32'h00000073, 32'h00100073};

    rst_n = 0; start_a = 0; start_b = 0;
    ifa.in_valid = 0; ifa.in_last = 0; ifa.in_cls = 0; ifa.in_rd = 0; ifa.in_rs1 = 0;
    ifa.in_rs2 = 0; ifa.in_funct3 = 0; ifa.in_funct7 = 0; ifa.in_imm = 0; ifa.imem_ready = 1;
    ifb.in_valid = 0; ifb.in_last = 0; ifb.in_cls = 0; ifb.in_rd = 0; ifb.in_rs1 = 0;
    ifb.in_rs2 = 0; ifb.in_funct3 = 0; ifb.in_funct7 = 0; ifb.in_imm = 0; ifb.imem_ready = 1;
    tick(); tick();
    check("rst_in_ready", ifa.in_ready, 0);
    check("rst_done", done_a, 0);
    check("rst_addr", ifa.imem_addr, 0);
    check("rst_wdata", ifa.imem_wdata, 0);
    rst_n = 1; tick();

    // single addi x1,x0,5
    pulse_start_a();
    send_a(3'b001, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1);
    check("t1_we", ifa.imem_we, 1);
    check("t1_addr", ifa.imem_addr, 32'h0);
    check("t1_wdata", ifa.imem_wdata, 32'h00500093);
    tick();
    check("t1_we_drop", ifa.imem_we, 0);
    wait_done_a(20);
    check("t1_busy_after", busy_a, 0);

    // mixed stream
    wlog.delete();
    pulse_start_a();
    send_a(3'b000, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 0);
    send_a(3'b011, 5'd0, 5'd1, 5'd2, 3'd3, 7'd0, 32'd8, 0);
    send_a(3'b100, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd4, 0);
    send_a(3'b111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 0);
    send_a(3'b111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1);
    wait_done_a(40);
    check("t2_count", wlog.size(), 5);
    for (int i = 0; i < 5 && i < wlog.size(); i++) begin
      check("t2_wdata", wlog[i].w, exp_w[i]);
      check("t2_addr", wlog[i].a, 32'(4 * i));
    end

    // backpressure: 6 bundles against a stalled memory
    wlog.delete();
    d0 = done_a_cnt;
    ifa.imem_ready = 0;
    pulse_start_a();
    for (int i = 0; i < 4; i++) send_a(3'b001, 5'(i + 1), 5'd2, 5'd0, 3'd0, 7'd0, 32'(i + 10), 0);
    first_w = enc(1, 1, 2, 0, 0, 0, 10);
    ifa.in_valid = 1; ifa.in_imm = 32'd14;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_in_ready_low", ifa.in_ready, 0);
      check("t3_addr_held", ifa.imem_addr, 32'h0);
      check("t3_wdata_held", ifa.imem_wdata, first_w);
      tick();
    end
    ifa.imem_ready = 1;
    send_a(3'b001, 5'd5, 5'd2, 5'd0, 3'd0, 7'd0, 32'd14, 0);
    send_a(3'b001, 5'd6, 5'd2, 5'd0, 3'd0, 7'd0, 32'd15, 1);
    wait_done_a(40);
    repeat (3) tick();
    check("t3_done_once", done_a_cnt - d0, 1);
    check("t3_count", wlog.size(), 6);

    // overflow on the MAX_WORDS=2 instance
    start_b = 1; @(posedge clk); #1; start_b = 0;
    send_b(32'd1, 0);
    send_b(32'd2, 0);
    send_b(32'd3, 1);
    n = 0;
    while (done_b_cnt == 0 && n < 50) begin @(posedge clk); #1; n++; end
    check("ovf_done", done_b_cnt, 1);
    check("ovf_writes", writes_b, 2);
    check("ovf_err", err_b, 1);
    start_b = 1; @(posedge clk); #1; start_b = 0;
    check("ovf_err_cleared", err_b, 0);
    send_b(32'd4, 1);
    n = 0;
    while (done_b_cnt == 1 && n < 50) begin @(posedge clk); #1; n++; end
    check("ovf_done2", done_b_cnt, 2);

    // reset mid-session with 3 words buffered
    ifa.imem_ready = 0;
    pulse_start_a();
    for (int i = 0; i < 3; i++) send_a(3'b110, 5'(i), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i << 12), 0);
    d0 = done_a_cnt;
    rst_n = 0; tick(); rst_n = 1;
    check("t5_we", ifa.imem_we, 0);
    check("t5_busy", busy_a, 0);
    ifa.imem_ready = 1;
    repeat (3) tick();
    check("t5_no_done", done_a_cnt, d0);
    wlog.delete();
    pulse_start_a();
    send_a(3'b101, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 1);
    wait_done_a(20);
    check("t5_restart_cnt", wlog.size(), 1);
    if (wlog.size() > 0) check("t5_restart_addr", wlog[0].a, 32'h0);

    // start pulsed while running is ignored
    wlog.delete();
    pulse_start_a();
    send_a(3'b010, 5'd4, 5'd5, 5'd0, 3'd2, 7'd0, 32'd16, 0);
    send_a(3'b010, 5'd4, 5'd5, 5'd0, 3'd2, 7'd0, 32'd20, 0);
    pulse_start_a();
    send_a(3'b010, 5'd4, 5'd5, 5'd0, 3'd2, 7'd0, 32'd24, 0);
    send_a(3'b010, 5'd4, 5'd5, 5'd0, 3'd2, 7'd0, 32'd28, 1);
    wait_done_a(40);
    check("t6_count", wlog.size(), 4);
    for (int i = 0; i < 4 && i < wlog.size(); i++) check("t6_addr", wlog[i].a, 32'(4 * i));

    // randomized sessions with random memory stalls
    rnd_ready = 1;
    for (int s = 0; s < 4; s++) begin
      int len;
      len = $urandom_range(1, 10);
      pulse_start_a();
      for (int i = 0; i < len; i++) begin
        send_a(3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
               3'($urandom), 7'($urandom), $urandom, (i == len - 1));
        if ($urandom_range(0, 3) == 0) tick();
      end
      wait_done_a(2000);
    end
    rnd_ready = 0;
    ifa.imem_ready = 1;
    repeat (3) tick();
    check("final_queue_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/inst_encoder_loader.md
Name: inst_encoder_loader

Overview:
- Inverse of the main control decoder: takes an instruction class (same 3-bit class code the decoder emits as ALUOp) plus register, funct and immediate fields.
- Packs them into a 32-bit RISC-V instruction word, buffers words in a small FIFO, and writes them sequentially into instruction memory.
- Used as the boot/program loader in front of the single-cycle core's instruction memory, and by benches to build programs from fields.

Parameters:
- ADDR_W, 32, instruction memory byte-address width.
- BASE_ADDR, 0, byte address of the first word written after start.
- MAX_WORDS, 256, maximum words per load session; must be at least 1.
- FIFO_DEPTH, 4, power of 2, at least 2.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; begins a load session (accepted only in IDLE)
- in_valid  in  1  field bundle valid
- in_ready  out  1  bundle accepted when in_valid && in_ready
- in_last  in  1  marks final instruction of session
- in_cls  in  3  000 R, 001 I-ALU, 010 load, 011 store, 100 branch, 101 jal, 110 lui, 111 system
- in_rd / in_rs1 / in_rs2  in  5 each  register indices
- in_funct3  in  3
- in_funct7  in  7
- in_imm  in  32  immediate, byte offset for branch/jal
- imem_ready  in  1  memory can accept a write this cycle
- imem_we  out  1  write strobe
- imem_addr  out  ADDR_W  byte address, word aligned
- imem_wdata  out  32  encoded word
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at session end
- err_overflow  out  1  sticky; set when more than MAX_WORDS bundles offered

Behaviour:
- Reset (rst_n low at clk edge) has priority over all inputs. It clears:
  - FIFO and address counter (set to BASE_ADDR); word counter set to 0.
  - State goes to IDLE; all of in_ready, imem_we, done, busy, err_overflow go to 0; imem_addr goes to BASE_ADDR; imem_wdata goes to 0.
- Reset mid-session discards any buffered words, and no further writes occur.
- FSM states:
  - IDLE: start goes to RUN. Counters reload and err_overflow clears on that edge.
  - RUN: accept bundles. An accepted bundle with in_last=1 goes to FLUSH.
  - FLUSH: in_ready=0. Once the FIFO is empty and no write is pending, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored.
- in_ready = (state==RUN) && !fifo_full. There is no same-cycle push/pop bypass when full.
- Overflow: once word_count==MAX_WORDS in RUN, in_ready is forced 1 so upstream never hangs. Bundles are dropped, err_overflow is set, and in_last still ends the session.
- Encoding is combinational on the accepted bundle and is pushed into the FIFO at the accept edge. The opcode is derived from in_cls; unused fields are ignored.
  - R: funct7|rs2|rs1|funct3|rd|0110011
  - I-ALU: imm[11:0]|rs1|funct3|rd|0010011
  - load: same layout as I-ALU, opcode 0000011
  - store: imm[11:5]|rs2|rs1|funct3|imm[4:0]|0100011
  - branch: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|1100011; imm[0] is ignored
  - jal: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|1101111
  - lui: imm[31:12]|rd|0110111
  - system: imm[11:0]|00000|000|00000|1110011 (0 = ecall, 1 = ebreak)
- Write port:
  - imem_we = FIFO non-empty; imem_addr and imem_wdata come from the counter and the FIFO head.
  - A write completes on an edge where imem_we && imem_ready: pop the FIFO and add 4 to the address.
  - While imem_ready=0, imem_we, imem_addr and imem_wdata are held.
- Latency: a bundle accepted at edge N appears on imem_we after edge N (first cycle N+1) when the FIFO was empty.
- Ordering: words are written strictly in acceptance order. Addresses are contiguous and wrap modulo 2^ADDR_W.
- Simultaneous push and pop while not full is allowed, and occupancy is unchanged.

Decomposition:
- Shared package holds:
  - instruction class codes (shared with the main control decoder);
  - the 7-bit opcode constants: OPC_R, OPC_I, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_LUI, OPC_SYSTEM;
  - FSM state encoding (IDLE, RUN, FLUSH, DONE).
- One natural sub-module: inst_pack, a purely combinational packer (class and fields in, 32-bit word out), reusable by benches.
- The FIFO stays inline.

Test Plan:
- Single instruction, imem_ready=1: start; bundle cls=001, rd=1, rs1=0, funct3=0, imm=5, last=1.
  - Required: imem_we for 1 cycle next cycle, addr=0x0, wdata=0x00500093.
  - Required: done pulses after the write, then busy=0.
- Mixed stream, imem_ready=1: stream add x3,x1,x2 / sd x2,8(x1) / beq x1,x2,-4 / ecall / ebreak (last).
  - Required wdata: 0x002081B3, 0x0020B423, 0xFE208EE3, 0x00000073, 0x00100073.
  - Required addresses: 0x0, 0x4, 0x8, 0xC, 0x10.
- Backpressure: imem_ready=0 while 6 bundles are offered.
  - Required: in_ready drops after 4 accepts; imem outputs held stable.
  - Required: after imem_ready=1, all 6 words are written in order and done fires once.
- Overflow: MAX_WORDS=2, offer 3 bundles with the 3rd last.
  - Required: only 2 writes; err_overflow=1; done still pulses.
  - Required: next start clears err_overflow.
- Reset mid-session: rst_n low for 1 cycle while FIFO holds 3 words.
  - Required: imem_we=0 from the next cycle, busy=0, no done.
  - Required: a new session starts again at BASE_ADDR.
- Start while busy: pulse start in RUN.
  - Required: ignored; address sequence continues unchanged.
